// File: rtl/circuit1_pipe_pkg.sv
// Shared datapath parameters for the circuit1 family: default operand width,
// signedness and pipeline depth.
package circuit1_pipe_pkg;
  localparam int DATAWIDTH_DEF = 8;
  localparam bit SIGNED_DEF    = 1'b0;
  localparam int N_STAGES      = 2;
endpackage

// File: rtl/circuit1_pipe_stage.sv
// Valid-qualified pipeline register with a load enable and an asynchronous
// active-low clear. The data word is only captured with a valid beat.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/circuit1_pipe.sv
// Two-stage valid/ready datapath: S1 holds d=a+b, e=a+c, f=a*c; S2 holds
// z=max(d,e), x=f-d and the d-versus-e compare flags.
import circuit1_pipe_pkg::*;

module circuit1_pipe #(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter bit SIGNED    = SIGNED_DEF
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   a,
  input  logic [DATAWIDTH-1:0]   b,
  input  logic [DATAWIDTH-1:0]   c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH-1:0]   z,
  output logic [2*DATAWIDTH-1:0] x,
  output logic                   gt,
  output logic                   lt,
  output logic                   eq
);

  localparam int W   = DATAWIDTH;
  localparam int S1W = 4 * W;
  localparam int S2W = 3 * W + 3;

  logic           s1_v, s2_v, s1_load, s2_load;
  logic [S1W-1:0] s1_d, s1_q;
  logic [S2W-1:0] s2_d, s2_q;

  logic [W-1:0]   d_d, e_d, d_q, e_q, z_d;
  logic [2*W-1:0] a_x, c_x, f_d, f_q, dq_x, x_d;
  logic           gt_d, lt_d, eq_d;

  // A full S2 frees up in the same cycle it hands its result over, so the
  // whole chain can advance with input and output transferring together.
  assign s2_load  = !s2_v || out_ready;
  assign s1_load  = !s1_v || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    d_d  = a + b;
    e_d  = a + c;
    a_x  = SIGNED ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    c_x  = SIGNED ? {{W{c[W-1]}}, c} : {{W{1'b0}}, c};
    f_d  = a_x * c_x;
    s1_d = {d_d, e_d, f_d};
  end

  pipe_stage #(.WIDTH(S1W)) u_s1 (
    .clk_i   (Clk),
    .rst_n_i (Rst),
    .load_i  (s1_load),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_v),
    .data_o  (s1_q)
  );

  assign d_q = s1_q[4*W-1:3*W];
  assign e_q = s1_q[3*W-1:2*W];
  assign f_q = s1_q[2*W-1:0];

  always_comb begin
    if (SIGNED) begin
      gt_d = $signed(d_q) > $signed(e_q);
      lt_d = $signed(d_q) < $signed(e_q);
    end else begin
      gt_d = d_q > e_q;
      lt_d = d_q < e_q;
    end
    eq_d = d_q == e_q;
    z_d  = gt_d ? d_q : e_q;
    dq_x = SIGNED ? {{W{d_q[W-1]}}, d_q} : {{W{1'b0}}, d_q};
    x_d  = f_q - dq_x;
    s2_d = {z_d, x_d, gt_d, lt_d, eq_d};
  end

  pipe_stage #(.WIDTH(S2W)) u_s2 (
    .clk_i   (Clk),
    .rst_n_i (Rst),
    .load_i  (s2_load),
    .valid_i (s1_v),
    .data_i  (s2_d),
    .valid_o (s2_v),
    .data_o  (s2_q)
  );

  assign out_valid = s2_v;
  assign z         = s2_q[S2W-1:2*W+3];
  assign x         = s2_q[2*W+2:3];
  assign gt        = s2_q[2];
  assign lt        = s2_q[1];
  assign eq        = s2_q[0];

endmodule
